// File: rtl/jelly3_img_mosaic_bayer_core.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// jelly3_img_mosaic_bayer_core
//
// Re-mosaics an RGB pixel stream into a single-channel Bayer raw stream.
// Row/column parity is tracked from the framing flags. The parity and CFA
// phase of each pixel choose which colour component (R, G or B) is emitted.
// No arithmetic is applied: the chosen component is copied unchanged.
//
// Pipeline: two cke-qualified register stages, fixed latency of 2.
//   stage 1 : capture pixel, update row/col parity, capture phase
//   stage 2 : select R/G/B from parity ^ phase, register the raw sample
//
// Stream handshake: valid-only, no ready. A pixel is transferred on each
// rising edge where cke & s_img_valid. The downstream must accept every
// m_img_valid beat. When cke is 0, every register holds its value.
//
// Optional feature (macro JELLY3_IMG_MOSAIC_BAYER_PHASE_LATCH_EN):
//   defined   : param_phase is captured into a shadow register on the
//               frame-start pixel (row_first & col_first) and is used for the
//               whole frame. The frame-start pixel itself uses the new value.
//   undefined : param_phase is sampled on every valid pixel.
//
// Ports
//   clk, aresetn, cke            clock, async active-low reset, clock enable
//   param_phase[1:0]             CFA phase 0=RGGB 1=GRBG 2=GBRG 3=BGGR
//   s_img_row_first/row_last     input frame line flags
//   s_img_col_first/col_last     input line pixel flags
//   s_img_de, s_img_user         data enable, sideband (passed through)
//   s_img_data[3*DATA_BITS-1:0]  {B,G,R}, R in the LSBs
//   s_img_valid                  pixel strobe
//   m_img_*                      same flags/user/valid delayed by 2
//   m_img_data[DATA_BITS-1:0]    Bayer raw sample
// ---------------------------------------------------------------------------
module jelly3_img_mosaic_bayer_core #(
  parameter int DATA_BITS = 10,
  parameter int USER_BITS = 1
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   cke,
  input  logic [1:0]             param_phase,
  input  logic                   s_img_row_first,
  input  logic                   s_img_row_last,
  input  logic                   s_img_col_first,
  input  logic                   s_img_col_last,
  input  logic                   s_img_de,
  input  logic [USER_BITS-1:0]   s_img_user,
  input  logic [3*DATA_BITS-1:0] s_img_data,
  input  logic                   s_img_valid,
  output logic                   m_img_row_first,
  output logic                   m_img_row_last,
  output logic                   m_img_col_first,
  output logic                   m_img_col_last,
  output logic                   m_img_de,
  output logic [USER_BITS-1:0]   m_img_user,
  output logic [DATA_BITS-1:0]   m_img_data,
  output logic                   m_img_valid
);

  // ---------------- stage 1 registers ----------------
  logic                   st1_row_first_q;
  logic                   st1_row_last_q;
  logic                   st1_col_first_q;
  logic                   st1_col_last_q;
  logic                   st1_de_q;
  logic [USER_BITS-1:0]   st1_user_q;
  logic [3*DATA_BITS-1:0] st1_data_q;
  logic                   st1_valid_q;

  // Parity and phase of the most recent valid pixel. These are updated only
  // on valid pixels, so when st1_valid_q is set they belong to the stage-1
  // pixel.
  logic                   row_odd_q;
  logic                   col_odd_q;
  logic [1:0]             phase_q;

  // ---------------- stage 2 registers ----------------
  logic                   m_row_first_q;
  logic                   m_row_last_q;
  logic                   m_col_first_q;
  logic                   m_col_last_q;
  logic                   m_de_q;
  logic [USER_BITS-1:0]   m_user_q;
  logic [DATA_BITS-1:0]   m_data_q;
  logic                   m_valid_q;

  // ---------------- next-state logic ----------------
  logic                   frame_start;
  logic                   row_odd_d;
  logic                   col_odd_d;
  logic [1:0]             phase_d;
  logic [1:0]             sel_idx;
  logic [DATA_BITS-1:0]   m_data_d;

  assign frame_start = s_img_row_first & s_img_col_first;

  // Column parity restarts on every col_first. Row parity restarts on any
  // frame-start pixel (including a restart in the middle of a frame) and
  // otherwise toggles at each new line.
  always_comb begin
    col_odd_d = s_img_col_first ? 1'b0 : ~col_odd_q;
    row_odd_d = row_odd_q;
    if (frame_start) begin
      row_odd_d = 1'b0;
    end else if (s_img_col_first) begin
      row_odd_d = ~row_odd_q;
    end
  end

`ifdef JELLY3_IMG_MOSAIC_BAYER_PHASE_LATCH_EN
  logic [1:0] phase_lat_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      phase_lat_q <= 2'd0;
    end else if (cke && s_img_valid && frame_start) begin
      phase_lat_q <= param_phase;
    end
  end

  // The frame-start pixel bypasses the shadow so it sees the new phase.
  assign phase_d = frame_start ? param_phase : phase_lat_q;
`else
  assign phase_d = param_phase;
`endif

  // idx 0 -> R, idx 1/2 -> G, idx 3 -> B
  assign sel_idx = {row_odd_q ^ phase_q[1], col_odd_q ^ phase_q[0]};

  always_comb begin
    m_data_d = st1_data_q[DATA_BITS +: DATA_BITS];
    case (sel_idx)
      2'd0:    m_data_d = st1_data_q[0 +: DATA_BITS];
      2'd3:    m_data_d = st1_data_q[2*DATA_BITS +: DATA_BITS];
      default: m_data_d = st1_data_q[DATA_BITS +: DATA_BITS];
    endcase
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      st1_row_first_q <= 1'b0;
      st1_row_last_q  <= 1'b0;
      st1_col_first_q <= 1'b0;
      st1_col_last_q  <= 1'b0;
      st1_de_q        <= 1'b0;
      st1_user_q      <= '0;
      st1_data_q      <= '0;
      st1_valid_q     <= 1'b0;
      row_odd_q       <= 1'b0;
      col_odd_q       <= 1'b0;
      phase_q         <= 2'd0;
      m_row_first_q   <= 1'b0;
      m_row_last_q    <= 1'b0;
      m_col_first_q   <= 1'b0;
      m_col_last_q    <= 1'b0;
      m_de_q          <= 1'b0;
      m_user_q        <= '0;
      m_data_q        <= '0;
      m_valid_q       <= 1'b0;
    end else if (cke) begin
      // Stage 1: flags are delayed on every beat, including invalid ones.
      st1_row_first_q <= s_img_row_first;
      st1_row_last_q  <= s_img_row_last;
      st1_col_first_q <= s_img_col_first;
      st1_col_last_q  <= s_img_col_last;
      st1_de_q        <= s_img_de;
      st1_user_q      <= s_img_user;
      st1_valid_q     <= s_img_valid;
      if (s_img_valid) begin
        st1_data_q <= s_img_data;
        row_odd_q  <= row_odd_d;
        col_odd_q  <= col_odd_d;
        phase_q    <= phase_d;
      end

      // Stage 2: the raw sample holds across invalid beats.
      m_row_first_q <= st1_row_first_q;
      m_row_last_q  <= st1_row_last_q;
      m_col_first_q <= st1_col_first_q;
      m_col_last_q  <= st1_col_last_q;
      m_de_q        <= st1_de_q;
      m_user_q      <= st1_user_q;
      m_valid_q     <= st1_valid_q;
      if (st1_valid_q) begin
        m_data_q <= m_data_d;
      end
    end
  end

  assign m_img_row_first = m_row_first_q;
  assign m_img_row_last  = m_row_last_q;
  assign m_img_col_first = m_col_first_q;
  assign m_img_col_last  = m_col_last_q;
  assign m_img_de        = m_de_q;
  assign m_img_user      = m_user_q;
  assign m_img_data      = m_data_q;
  assign m_img_valid     = m_valid_q;

endmodule

// File: tb/tb_jelly3_img_mosaic_bayer_core.sv
`timescale 1ns/1ps
// Bench for jelly3_img_mosaic_bayer_core: directed frames with hand-computed
// Bayer raw sequences (pixel RGB fixed at {B=3,G=2,R=1}).
module tb_jelly3_img_mosaic_bayer_core;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cke = 1'b1;
  logic [1:0]  param_phase = 2'd0;
  logic        s_img_row_first = 1'b0;
  logic        s_img_row_last = 1'b0;
  logic        s_img_col_first = 1'b0;
  logic        s_img_col_last = 1'b0;
  logic        s_img_de = 1'b0;
  logic [0:0]  s_img_user = 1'b0;
  logic [29:0] s_img_data = '0;
  logic        s_img_valid = 1'b0;
  logic        m_img_row_first;
  logic        m_img_row_last;
  logic        m_img_col_first;
  logic        m_img_col_last;
  logic        m_img_de;
  logic [0:0]  m_img_user;
  logic [9:0]  m_img_data;
  logic        m_img_valid;

  always #5 clk = ~clk;

  jelly3_img_mosaic_bayer_core #(
    .DATA_BITS(10),
    .USER_BITS(1)
  ) dut (
    .clk             (clk),
    .aresetn         (aresetn),
    .cke             (cke),
    .param_phase     (param_phase),
    .s_img_row_first (s_img_row_first),
    .s_img_row_last  (s_img_row_last),
    .s_img_col_first (s_img_col_first),
    .s_img_col_last  (s_img_col_last),
    .s_img_de        (s_img_de),
    .s_img_user      (s_img_user),
    .s_img_data      (s_img_data),
    .s_img_valid     (s_img_valid),
    .m_img_row_first (m_img_row_first),
    .m_img_row_last  (m_img_row_last),
    .m_img_col_first (m_img_col_first),
    .m_img_col_last  (m_img_col_last),
    .m_img_de        (m_img_de),
    .m_img_user      (m_img_user),
    .m_img_data      (m_img_data),
    .m_img_valid     (m_img_valid)
  );

  // ---------------- scoreboard ----------------
  // record = {row_first,row_last,col_first,col_last,de,user,data[9:0]}
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int          checks = 0;
  int          errors = 0;
  int          tile[4];     // raw for (r%2,c%2) in order r0c0,r0c1,r1c0,r1c1

  // ---------------- driver tasks ----------------
  // One clock edge; outputs are sampled 1 ns later. A new output beat is
  // recorded only when the edge was cke-qualified.
  task automatic tick();
    @(posedge clk);
    #1;
    if (cke && m_img_valid) begin
      obs_q.push_back({m_img_row_first, m_img_row_last, m_img_col_first,
                       m_img_col_last, m_img_de, m_img_user, m_img_data});
    end
  endtask

  task automatic pix(input logic rf, input logic rl, input logic cf,
                     input logic cl, input logic de, input logic us,
                     input int raw);
    cke             = 1'b1;
    s_img_row_first = rf;
    s_img_row_last  = rl;
    s_img_col_first = cf;
    s_img_col_last  = cl;
    s_img_de        = de;
    s_img_user      = us;
    s_img_data      = {10'd3, 10'd2, 10'd1};
    s_img_valid     = 1'b1;
    exp_q.push_back({rf, rl, cf, cl, de, us, 10'(raw)});
    tick();
  endtask

  task automatic flush();
    cke             = 1'b1;
    s_img_valid     = 1'b0;
    s_img_row_first = 1'b0;
    s_img_col_first = 1'b0;
    s_img_row_last  = 1'b0;
    s_img_col_last  = 1'b0;
    repeat (3) tick();
  endtask

  task automatic frame(input int w, input int h);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        pix(r == 0, r == h - 1, c == 0, c == w - 1, 1'b1, 1'((r + c) & 1),
            tile[(r % 2) * 2 + (c % 2)]);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    aresetn         = 1'b0;
    cke             = 1'b1;
    s_img_valid     = 1'b1;
    s_img_row_first = 1'b1;
    s_img_row_last  = 1'b1;
    s_img_col_first = 1'b1;
    s_img_col_last  = 1'b1;
    s_img_de        = 1'b1;
    s_img_user      = 1'b1;
    s_img_data      = '1;
    repeat (3) tick();
    checks++;
    if (m_img_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", m_img_valid);
    end
    checks++;
    if (m_img_data !== 10'd0) begin
      errors++; $display("FAIL reset_data: got %h expected 000", m_img_data);
    end
    checks++;
    if ({m_img_row_first, m_img_row_last, m_img_col_first, m_img_col_last,
         m_img_de, m_img_user} !== 6'd0) begin
      errors++; $display("FAIL reset_flags: got %b%b%b%b%b%b expected 000000",
        m_img_row_first, m_img_row_last, m_img_col_first, m_img_col_last,
        m_img_de, m_img_user);
    end

    // Release and check the 2-cycle latency of the first pixel.
    aresetn         = 1'b1;
    s_img_row_last  = 1'b0;
    s_img_col_last  = 1'b0;
    s_img_user      = 1'b0;
    s_img_data      = {10'd3, 10'd2, 10'd1};
    tick();
    checks++;
    if (m_img_valid !== 1'b0) begin
      errors++; $display("FAIL latency_1cycle: got valid %b expected 0", m_img_valid);
    end
    s_img_valid = 1'b0;
    tick();
    checks++;
    if ({m_img_valid, m_img_row_first, m_img_col_first, m_img_data} !== {3'b111, 10'd1}) begin
      errors++; $display("FAIL latency_2cycle: got v=%b rf=%b cf=%b d=%0d expected v=1 rf=1 cf=1 d=1",
        m_img_valid, m_img_row_first, m_img_col_first, m_img_data);
    end

    // Asynchronous assertion mid-flight clears outputs without a clock edge.
    s_img_valid = 1'b1;
    tick();
    s_img_valid = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if (m_img_valid !== 1'b0 || m_img_data !== 10'd0) begin
      errors++; $display("FAIL async_reset: got v=%b d=%0d expected v=0 d=0", m_img_valid, m_img_data);
    end
    @(posedge clk);
    #1 aresetn = 1'b1;
    tick();
    tick();
    checks++;
    if (m_img_valid !== 1'b0) begin
      errors++; $display("FAIL reset_flush: got valid %b expected 0", m_img_valid);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_phases();
    int tiles[4][4] = '{'{1, 2, 2, 3}, '{2, 1, 3, 2}, '{2, 3, 1, 2}, '{3, 2, 2, 1}};
    for (int ph = 0; ph < 4; ph++) begin
      param_phase = 2'(ph);
      tile = tiles[ph];
      frame(4, 2);
      // Last pixel is still in flight: only 7 of 8 outputs seen so far.
      checks++;
      if (obs_q.size() != 7) begin
        errors++; $display("FAIL phase%0d_latency: got %0d outputs expected 7", ph, obs_q.size());
      end
      flush();
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL phase%0d_count: got %0d expected %0d", ph, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL phase%0d_pix%0d: got %h expected %h", ph, i, obs_q[i], exp_q[i]);
        end
      end
      obs_q.delete();
      exp_q.delete();
    end
    param_phase = 2'd0;
  endtask

  task automatic test_gaps();
    logic [16:0] snap;
    int          nb;
    bit          hold;
    param_phase = 2'd0;
    tile = '{1, 2, 2, 3};
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 6; c++) begin
        nb = (r == 1 && c == 2) ? 2 : $urandom_range(0, 2);
        for (int b = 0; b < nb; b++) begin
          hold = (r == 1 && c == 2) || ($urandom_range(0, 1) == 1);
          s_img_valid     = 1'($urandom_range(0, 1));
          s_img_row_first = 1'($urandom_range(0, 1));
          s_img_col_first = 1'($urandom_range(0, 1));
          if (hold) begin
            cke  = 1'b0;
            snap = {m_img_valid, m_img_row_first, m_img_row_last, m_img_col_first,
                    m_img_col_last, m_img_de, m_img_user, m_img_data};
            tick();
            checks++;
            if ({m_img_valid, m_img_row_first, m_img_row_last, m_img_col_first,
                 m_img_col_last, m_img_de, m_img_user, m_img_data} !== snap) begin
              errors++; $display("FAIL cke_hold r%0d c%0d: got %h expected %h", r, c,
                {m_img_valid, m_img_row_first, m_img_row_last, m_img_col_first,
                 m_img_col_last, m_img_de, m_img_user, m_img_data}, snap);
            end
            cke = 1'b1;
          end else begin
            s_img_valid = 1'b0;
            tick();
          end
        end
        // Last column is sent as blanking (de=0) but still selected normally.
        pix(r == 0, r == 3, c == 0, c == 5, c != 5, 1'((r + c) & 1),
            tile[(r % 2) * 2 + (c % 2)]);
      end
    end
    flush();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL gaps_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL gaps_pix%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_restart();
    // Restart (row_first & col_first) at row 1 col 3 of a 6x3 frame.
    int  exp_tbl[18] = '{1, 2, 1, 2, 1, 2,
                         2, 3, 2, 1, 2, 1,
                         2, 3, 2, 3, 2, 3};
    logic rs;
    param_phase = 2'd0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 6; c++) begin
        rs = (r == 1 && c == 3);
        pix((r == 0 && c == 0) || rs, r == 2, c == 0 || rs, c == 5, 1'b1, 1'b0,
            exp_tbl[r * 6 + c]);
      end
    end
    flush();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL restart_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL restart_pix%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_phase_change();
`ifdef JELLY3_IMG_MOSAIC_BAYER_PHASE_LATCH_EN
    int exp_tbl[8] = '{1, 2, 1, 2, 2, 3, 2, 3};
`else
    int exp_tbl[8] = '{1, 2, 3, 2, 2, 1, 2, 1};
`endif
    param_phase = 2'd0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) param_phase = 2'd3;
      pix(i == 0, i >= 4, (i % 4) == 0, (i % 4) == 3, 1'b1, 1'b0, exp_tbl[i]);
    end
    // Next frame start picks up phase 3 in both builds.
    pix(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3);
    pix(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2);
    flush();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL phase_change_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL phase_change_pix%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
    param_phase = 2'd0;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_phases();
    test_gaps();
    test_restart();
    test_phase_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
